imm_ext_pipe: RTL and testbench
===============================

Name: imm_ext_pipe

Overview:
Pipelined, parametrised immediate extender for the pipelined RV core. It decodes I/S/B/U/J immediates plus the CSR zero-extended uimm from instruction bits [31:7] and sign-extends them to Reg_size (RV32 or RV64). It registers the result behind a valid/ready handshake with a 2-entry skid buffer, so in_ready is a flop output. It sits between the decode and execute stages and carries a sideband tag (PC/ROB id) alongside the immediate.

Parameters:
Reg_size, 32, output datapath width; legal values 32 or 64 only (elaboration $error otherwise)
TAG_W, 32, width of the sideband tag carried with each immediate

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous pipeline flush; drops all buffered entries
in_valid  input  1  Im_type/Instr/in_tag valid this cycle
in_ready  output  1  block can accept an entry this cycle
Im_type  input  Imm_ex_op  immediate format select (controls package enum)
Instr  input  25  instruction bits [31:7]; Instr[i] = instr[i+7]
in_tag  input  TAG_W  sideband, passed through unchanged
out_valid  output  1  Im_out/out_tag valid
out_ready  input  1  consumer accepts the output this cycle
Im_out  output  Reg_size (signed)  extended immediate
out_tag  output  TAG_W  tag of the current output entry
imm_illegal  output  1  current output came from an Im_type encoding outside the enum

Behaviour:
- Formats (instruction bit numbering):
  - I: sext(instr[31:20])
  - S: sext({instr[31:25],instr[11:7]})
  - B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
  - U: sext({instr[31:12],12'h000}); bit 31 replicates into [63:32] when Reg_size=64
  - J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
  - Z_TYPE: zext(instr[19:15])
- Unlisted Im_type encoding: immediate = 0, imm_illegal = 1 for that entry.
- Storage: main output register (out_valid, Im_out, out_tag, imm_illegal) plus one skid register of the same fields.
- in_ready = !skid_valid (registered). Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Latency: an accepted entry appears on the output the cycle after acceptance when the main register is empty or popping that cycle.
- Accept while main is full and not popping: the entry goes to skid; in_ready drops the next cycle.
- Pop with skid full: skid moves to main on the same edge; a new accept is impossible that cycle because in_ready = 0.
- Pop and accept together with skid empty: the new entry replaces main; out_valid stays 1.
- Ordering: strictly FIFO. No entry is lost or duplicated while flush = 0.
- Output stability: Im_out, out_tag and imm_illegal are held stable while out_valid & !out_ready.
- flush = 1: main and skid valids clear on the next edge. A concurrent in_valid is dropped; the concurrent pop still completes for the consumer. flush has priority over every other event.
- reset asserted (any time, including mid-stall): out_valid = 0, skid_valid = 0, in_ready = 1, Im_out = 0, out_tag = 0, imm_illegal = 0, all immediately.
- First accept is possible on the first rising edge after reset deasserts.
- Extension logic is purely combinational in front of the registers. No arithmetic overflow cases exist; all results are exact bit selections.

Decomposition:
- controls package: extend the Imm_ex_op enum by appending Z_TYPE after J_TYPE. Existing encodings are unchanged. Benches must use explicit enum names, not .next()/.last().
- Also in controls: a localparam INSTR_IMM_W = 25.
- Sub-module imm_ext_comb (parameter Reg_size): combinational (Im_type, Instr) -> (imm, illegal). imm_ext_pipe instantiates it and adds the skid/handshake logic.

Test Plan:
- Reg_size=32, out_ready=1, I_TYPE, Instr=25'b1100101110010001000000011 -> one cycle later out_valid=1, Im_out=-839, out_tag matches.
- S_TYPE, Instr=25'b0000000_01110_00010_010_01000 -> Im_out=8. B_TYPE, Instr=25'b0_000000_01010_10011_000_1000_0 -> Im_out=16.
- U_TYPE, Instr=25'b1010111110111001111101010 -> 0xAFB9F000; same input with Reg_size=64 -> 0xFFFFFFFFAFB9F000. J_TYPE, Instr=25'b10111010111100001011_01100 -> 0xFFF0BBAE. Z_TYPE with instr[19:15]=5'b11111 -> 31.
- Backpressure: out_ready=0, present tags 1, 2, 3 back-to-back -> tags 1 and 2 accepted, in_ready=0 from the cycle after tag 2. Raise out_ready -> outputs 1, 2, then 3 (after re-accept), in order with no gaps. Im_out is stable while stalled.
- Flush with both entries full plus concurrent in_valid -> next cycle out_valid=0, in_ready=1; the dropped tag never appears.
- Assert reset mid-stall (skid full) -> out_valid=0, in_ready=1 immediately, without waiting for a clock edge. Drive an illegal Im_type encoding -> Im_out=0, imm_illegal=1.

Source files
------------

// File: rtl/imm_ext_pipe_pkg.sv
// Shared control encodings for the decode/execute boundary.
// Imm_ex_op selects the immediate format handed to the extender.
package controls;

  localparam int unsigned INSTR_IMM_W = 25;
  localparam int unsigned IMM_OP_W    = 3;

  typedef enum logic [IMM_OP_W-1:0] {
    I_TYPE = 3'd0,
    S_TYPE = 3'd1,
    B_TYPE = 3'd2,
    U_TYPE = 3'd3,
    J_TYPE = 3'd4,
    Z_TYPE = 3'd5
  } Imm_ex_op;

endpackage

// File: rtl/imm_ext_comb.sv
// Combinational immediate decode/extend from instruction bits [31:7].
// Instr[i] holds instr[i+7]; unlisted formats yield zero and flag illegal.
module imm_ext_comb
  import controls::*;
#(
  parameter int unsigned Reg_size = 32
) (
  input  Imm_ex_op                   Im_type,
  input  logic [INSTR_IMM_W-1:0]     Instr,
  output logic signed [Reg_size-1:0] imm,
  output logic                       illegal
);

  if (Reg_size != 32 && Reg_size != 64) begin : g_bad_size
    $error("imm_ext_comb: Reg_size must be 32 or 64, got %0d", Reg_size);
  end

  logic signed [11:0] i_imm;
  logic signed [11:0] s_imm;
  logic signed [12:0] b_imm;
  logic signed [31:0] u_imm;
  logic signed [20:0] j_imm;
  logic        [4:0]  z_imm;

  // Field gathering in instruction bit order, shifted down by 7.
  always_comb begin
    i_imm = Instr[24:13];
    s_imm = {Instr[24:18], Instr[4:0]};
    b_imm = {Instr[24], Instr[0], Instr[23:18], Instr[4:1], 1'b0};
    u_imm = {Instr[24:5], 12'h000};
    j_imm = {Instr[24], Instr[12:5], Instr[13], Instr[23:14], 1'b0};
    z_imm = Instr[12:8];
  end

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (Im_type)
      I_TYPE:  imm = Reg_size'(i_imm);
      S_TYPE:  imm = Reg_size'(s_imm);
      B_TYPE:  imm = Reg_size'(b_imm);
      U_TYPE:  imm = Reg_size'(u_imm);
      J_TYPE:  imm = Reg_size'(j_imm);
      Z_TYPE:  imm = Reg_size'($unsigned(z_imm));
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender with valid/ready handshake and a one-deep
// skid register so that in_ready comes straight from a flop.
module imm_ext_pipe
  import controls::*;
#(
  parameter int unsigned Reg_size = 32,
  parameter int unsigned TAG_W    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  Imm_ex_op                   Im_type,
  input  logic [INSTR_IMM_W-1:0]     Instr,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [Reg_size-1:0] Im_out,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       imm_illegal
);

  logic signed [Reg_size-1:0] ext_imm;
  logic                       ext_illegal;

  imm_ext_comb #(
    .Reg_size (Reg_size)
  ) u_comb (
    .Im_type (Im_type),
    .Instr   (Instr),
    .imm     (ext_imm),
    .illegal (ext_illegal)
  );

  logic                       out_valid_q, out_valid_d;
  logic signed [Reg_size-1:0] out_imm_q,   out_imm_d;
  logic [TAG_W-1:0]           out_tag_q,   out_tag_d;
  logic                       out_ill_q,   out_ill_d;
  logic                       skid_valid_q, skid_valid_d;
  logic signed [Reg_size-1:0] skid_imm_q,   skid_imm_d;
  logic [TAG_W-1:0]           skid_tag_q,   skid_tag_d;
  logic                       skid_ill_q,   skid_ill_d;
  logic                       in_ready_q,   in_ready_d;
  logic                       accept;
  logic                       pop;

  // Skid buffer control: main refills from skid first to preserve order.
  always_comb begin
    accept       = in_valid & in_ready_q & ~flush;
    pop          = out_valid_q & out_ready;
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_tag_d    = out_tag_q;
    out_ill_d    = out_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_ill_d   = skid_ill_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_tag_d    = skid_tag_q;
        out_ill_d    = skid_ill_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_imm_d   = ext_imm;
        out_tag_d   = in_tag;
        out_ill_d   = ext_illegal;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = ext_imm;
      skid_tag_d   = in_tag;
      skid_ill_d   = ext_illegal;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_tag_q    <= '0;
      out_ill_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_ill_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_tag_q    <= out_tag_d;
      out_ill_q    <= out_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_ill_q   <= skid_ill_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign Im_out      = out_imm_q;
  assign out_tag     = out_tag_q;
  assign imm_illegal = out_ill_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: one RV32 and one RV64 instance share stimulus.
module tb_imm_ext_pipe;
  import controls::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  Imm_ex_op    im_type;
  logic [24:0] instr;
  logic [31:0] in_tag;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] im_out32, out_tag32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] im_out64;
  logic [31:0] out_tag64;

  int n_checks = 0;
  int n_errors = 0;

  imm_ext_pipe #(.Reg_size(32), .TAG_W(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready32), .Im_type(im_type), .Instr(instr), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .Im_out(im_out32),
    .out_tag(out_tag32), .imm_illegal(ill32)
  );

  imm_ext_pipe #(.Reg_size(64), .TAG_W(32)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready64), .Im_type(im_type), .Instr(instr), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .Im_out(im_out64),
    .out_tag(out_tag64), .imm_illegal(ill64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one entry for a single cycle, then sample just after the edge.
  task automatic send(input Imm_ex_op t, input logic [24:0] ins, input logic [31:0] tg);
    im_type  = t;
    instr    = ins;
    in_tag   = tg;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [24:0] i_instr(input logic [31:0] v);
    return {v[11:0], 13'h0};
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    im_type = I_TYPE; instr = '0; in_tag = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid32), 64'd0);
    chk("rst_in_ready",  64'(in_ready32),  64'd1);
    chk("rst_im_out",    64'(im_out32),    64'd0);
    chk("rst_out_tag",   64'(out_tag32),   64'd0);
    chk("rst_illegal",   64'(ill32),       64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Format decode, streaming with out_ready = 1.
    send(I_TYPE, 25'b1100101110010001000000011, 32'hA1);
    chk("i_valid",  64'(out_valid32), 64'd1);
    chk("i_imm32",  64'(im_out32),    64'h0000_0000_FFFF_FCB9);
    chk("i_imm64",  im_out64,         64'hFFFF_FFFF_FFFF_FCB9);
    chk("i_tag",    64'(out_tag32),   64'hA1);
    chk("i_ill",    64'(ill32),       64'd0);
    send(S_TYPE, 25'b0000000_01110_00010_010_01000, 32'hA2);
    chk("s_imm32",  64'(im_out32),    64'd8);
    chk("s_tag",    64'(out_tag32),   64'hA2);
    send(B_TYPE, 25'b0_000000_01010_10011_000_1000_0, 32'hA3);
    chk("b_imm32",  64'(im_out32),    64'd16);
    send(U_TYPE, 25'b1010111110111001111101010, 32'hA4);
    chk("u_imm32",  64'(im_out32),    64'h0000_0000_AFB9_F000);
    chk("u_imm64",  im_out64,         64'hFFFF_FFFF_AFB9_F000);
    send(J_TYPE, 25'b10111010111100001011_01100, 32'hA5);
    chk("j_imm32",  64'(im_out32),    64'h0000_0000_FFF0_BBAE);
    chk("j_imm64",  im_out64,         64'hFFFF_FFFF_FFF0_BBAE);
    send(Z_TYPE, 25'h1FF_FFFF, 32'hA6);
    chk("z_imm32",  64'(im_out32),    64'd31);
    chk("z_imm64",  im_out64,         64'd31);
    send(Imm_ex_op'(3'd6), 25'h1FF_FFFF, 32'hA7);
    chk("ill_imm32", 64'(im_out32),   64'd0);
    chk("ill_imm64", im_out64,        64'd0);
    chk("ill_flag",  64'(ill32),      64'd1);
    chk("ill_tag",   64'(out_tag32),  64'hA7);
    @(posedge clk); #1;
    chk("idle_valid", 64'(out_valid32), 64'd0);

    // Backpressure: tags 1,2 fill main+skid, tag 3 waits.
    out_ready = 1'b0;
    send(I_TYPE, i_instr(32'd1), 32'd1);
    chk("bp1_tag",   64'(out_tag32),  64'd1);
    chk("bp1_ready", 64'(in_ready32), 64'd1);
    send(I_TYPE, i_instr(32'd2), 32'd2);
    chk("bp2_ready", 64'(in_ready32), 64'd0);
    chk("bp2_tag",   64'(out_tag32),  64'd1);
    im_type = I_TYPE; instr = i_instr(32'd3); in_tag = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp3_ready",  64'(in_ready32), 64'd0);
    chk("bp3_stable", 64'(im_out32),   64'd1);
    chk("bp3_tag",    64'(out_tag32),  64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain2_valid", 64'(out_valid32), 64'd1);
    chk("drain2_tag",   64'(out_tag32),   64'd2);
    chk("drain2_imm",   64'(im_out32),    64'd2);
    chk("drain2_ready", 64'(in_ready32),  64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("drain3_valid", 64'(out_valid32), 64'd1);
    chk("drain3_tag",   64'(out_tag32),   64'd3);
    @(posedge clk); #1;
    chk("drain_empty",  64'(out_valid32), 64'd0);

    // Flush with main and skid full and a concurrent in_valid.
    out_ready = 1'b0;
    send(I_TYPE, i_instr(32'd10), 32'd10);
    send(I_TYPE, i_instr(32'd11), 32'd11);
    chk("fl_full_ready", 64'(in_ready32), 64'd0);
    flush = 1'b1; in_valid = 1'b1; in_tag = 32'd12; instr = i_instr(32'd12);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_valid", 64'(out_valid32), 64'd0);
    chk("fl_ready", 64'(in_ready32),  64'd1);
    @(posedge clk); #1;
    chk("fl_drop1", 64'(out_valid32), 64'd0);
    @(posedge clk); #1;
    chk("fl_drop2", 64'(out_valid32), 64'd0);

    // Asynchronous reset while stalled with skid full.
    out_ready = 1'b0;
    send(I_TYPE, i_instr(32'd20), 32'd20);
    send(I_TYPE, i_instr(32'd21), 32'd21);
    chk("ar_pre_ready", 64'(in_ready32), 64'd0);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", 64'(out_valid32), 64'd0);
    chk("ar_ready", 64'(in_ready32),  64'd1);
    chk("ar_imm",   64'(im_out32),    64'd0);
    chk("ar_tag",   64'(out_tag32),   64'd0);
    chk("ar_v64",   64'(out_valid64), 64'd0);
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    send(U_TYPE, 25'b1010111110111001111101010, 32'h33);
    chk("post_rst_valid", 64'(out_valid32), 64'd1);
    chk("post_rst_tag",   64'(out_tag32),   64'h33);
    chk("post_rst_imm64", im_out64,         64'hFFFF_FFFF_AFB9_F000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
